// File: rtl/ascii_seg_scroller.sv
// ASCII byte FIFO feeding a 7-segment display that holds each glyph for HOLD_CYCLES.
// Define SEG_GAP_EN to insert a blank GAP_CYCLES interval between consecutive glyphs.
module ascii_seg_scroller #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 250000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [7:0]              char_in,
  input  logic                    char_valid,
  output logic                    char_ready,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_level
);

`ifdef SEG_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (GAP_EN && GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_next;
  logic          full, empty, push, pop;
  state_t        state;
  logic [CW-1:0] cnt;

  function automatic logic [6:0] decode(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "0": decode = 7'h3F;  "1": decode = 7'h06;  "2": decode = 7'h5B;
      "3": decode = 7'h4F;  "4": decode = 7'h66;  "5": decode = 7'h6D;
      "6": decode = 7'h7D;  "7": decode = 7'h07;  "8": decode = 7'h7F;
      "9": decode = 7'h6F;  "A": decode = 7'h77;  "B": decode = 7'h7C;
      "C": decode = 7'h39;  "D": decode = 7'h5E;  "E": decode = 7'h79;
      "F": decode = 7'h71;  "G": decode = 7'h3D;  "H": decode = 7'h76;
      "I": decode = 7'h06;  "J": decode = 7'h1E;  "L": decode = 7'h38;
      "N": decode = 7'h54;  "O": decode = 7'h3F;  "P": decode = 7'h73;
      "R": decode = 7'h50;  "S": decode = 7'h6D;  "T": decode = 7'h78;
      "U": decode = 7'h3E;  "Y": decode = 7'h6E;  " ": decode = 7'h00;
      default: decode = 7'h40;
    endcase
  endfunction

  assign empty      = (fifo_level == '0);
  assign char_ready = !full;
  assign dp_out     = full;
  assign push       = char_valid && !full;

  // Pop decision mirrors the FSM's load points; emptiness is the registered level.
  always_comb begin
    pop = 1'b0;
    if (ena && !empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        SHOW:    pop = !GAP_EN && (cnt == HOLD_LAST);
        GAP:     pop = (cnt == GAP_LAST);
        default: pop = 1'b0;
      endcase
    end
  end

  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + (AW+1)'(1);
      2'b01:   level_next = fifo_level - (AW+1)'(1);
      default: level_next = fifo_level;
    endcase
  end

  // Storage carries no reset; occupancy is tracked by the level/pointers only.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      full       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      full       <= (level_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      seg_out <= 7'h00;
      busy    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (pop) begin
            seg_out <= decode(mem[rd_ptr]);
            cnt     <= '0;
            state   <= SHOW;
            busy    <= 1'b1;
          end
        end
        SHOW: begin
          if (cnt != HOLD_LAST) begin
            cnt <= cnt + CW'(1);
          end else if (GAP_EN) begin
            seg_out <= 7'h00;
            cnt     <= '0;
            state   <= GAP;
          end else if (pop) begin
            seg_out <= decode(mem[rd_ptr]);
            cnt     <= '0;
          end else begin
            seg_out <= 7'h00;
            cnt     <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end
        GAP: begin
          if (cnt != GAP_LAST) begin
            cnt <= cnt + CW'(1);
          end else if (pop) begin
            seg_out <= decode(mem[rd_ptr]);
            cnt     <= '0;
            state   <= SHOW;
          end else begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_seg_scroller.sv
// Bench for ascii_seg_scroller: directed scenarios plus random traffic against a queue-based model.
module tb_ascii_seg_scroller;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;
`ifdef SEG_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam logic [6:0] SEG_TAB [30] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h06, 7'h1E,
    7'h38, 7'h54, 7'h3F, 7'h73, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h6E, 7'h00};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready, dp_out, busy;
  logic [6:0] seg_out;
  logic [2:0] fifo_level;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a queue of pending bytes plus the glyph on show and
  // how many enabled cycles of the current phase remain.
  byte unsigned q[$];
  int           phase;   // 0 idle, 1 showing a glyph, 2 blank gap
  int           left;
  logic [6:0]   m_seg;
  bit           m_pushed;

  ascii_seg_scroller #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .seg_out(seg_out), .dp_out(dp_out), .busy(busy),
    .fifo_level(fifo_level));

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input byte unsigned c);
    string keys;
    byte unsigned u;
    keys = "0123456789ABCDEFGHIJLNOPRSTUY ";
    u = (c >= 8'h61 && c <= 8'h7A) ? byte'(c - 8'h20) : c;
    for (int i = 0; i < keys.len(); i++)
      if (keys[i] == u) return SEG_TAB[i];
    return 7'h40;
  endfunction

  task automatic model_reset();
    q.delete();
    phase = 0;
    left = 0;
    m_seg = 7'h00;
    m_pushed = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] c, input logic e);
    int  pre;
    bit  do_pop;
    pre = q.size();
    do_pop = 1'b0;
    m_pushed = v && (pre < DEPTH);
    if (e) begin
      if (phase == 0) begin
        do_pop = (pre > 0);
      end else if (phase == 1) begin
        left--;
        if (left == 0) begin
          if (GAP_EN) begin phase = 2; left = GAP; m_seg = 7'h00; end
          else if (pre > 0) do_pop = 1'b1;
          else begin phase = 0; m_seg = 7'h00; end
        end
      end else begin
        left--;
        if (left == 0) begin
          if (pre > 0) do_pop = 1'b1;
          else phase = 0;
        end
      end
      if (do_pop) begin
        m_seg = seg_of(q.pop_front());
        phase = 1;
        left = HOLD;
      end
    end
    if (m_pushed) q.push_back(c);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("seg_out",    {1'b0, seg_out},     {1'b0, m_seg});
    check("fifo_level", {5'd0, fifo_level},  8'(q.size()));
    check("char_ready", {7'd0, char_ready},  {7'd0, q.size() < DEPTH});
    check("dp_out",     {7'd0, dp_out},      {7'd0, q.size() == DEPTH});
    check("busy",       {7'd0, busy},        {7'd0, phase != 0});
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic e);
    char_valid = v;
    char_in = c;
    ena = e;
    @(posedge clk);
    model_edge(v, c, e);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    string burst;
    int    idx;
    logic  v;
    logic [7:0] c;

    model_reset();
    #12;
    check("rst seg_out", {1'b0, seg_out}, 8'h00);
    check("rst level", {5'd0, fifo_level}, 8'h00);
    check("rst ready", {7'd0, char_ready}, 8'h01);
    check("rst dp", {7'd0, dp_out}, 8'h00);
    check("rst busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;

    // 1: single 'A'
    step(1'b1, 8'h41, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("A first cycle", {1'b0, seg_out}, 8'h77);
    idle(3);
    check("A last cycle", {1'b0, seg_out}, 8'h77);
    idle(1);
    check("A blank after", {1'b0, seg_out}, 8'h00);
    idle(4);

    // 2: "Fu" back to back
    step(1'b1, 8'h46, 1'b1);
    step(1'b1, 8'h75, 1'b1);
    idle(14);

    // 3: sustained valid while showing, exercises backpressure
    step(1'b1, 8'h48, 1'b1);
    burst = "ELP012";
    idx = 0;
    for (int i = 0; i < 60 && idx < 6; i++) begin
      step(1'b1, burst[idx], 1'b1);
      if (m_pushed) idx++;
    end
    check("burst accepted", 8'(idx), 8'd6);
    idle(50);

    // 4: freeze mid-glyph with pushes still landing
    step(1'b1, 8'h53, 1'b1);
    idle(2);
    step(1'b1, 8'h31, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    idle(16);

    // 5: dash, blank and digit glyphs
    step(1'b1, 8'h7E, 1'b1);
    step(1'b1, 8'h20, 1'b1);
    step(1'b1, 8'h37, 1'b1);
    idle(20);

    // 6: asynchronous reset mid-glyph with three buffered
    step(1'b1, 8'h41, 1'b1);
    step(1'b1, 8'h62, 1'b1);
    step(1'b1, 8'h63, 1'b1);
    step(1'b1, 8'h64, 1'b1);
    check("pre-reset level", {5'd0, fifo_level}, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async seg_out", {1'b0, seg_out}, 8'h00);
    check("async level", {5'd0, fifo_level}, 8'h00);
    check("async ready", {7'd0, char_ready}, 8'h01);
    check("async busy", {7'd0, busy}, 8'h00);
    model_reset();
    char_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Random traffic; a stalled byte is held until it is accepted.
    v = 1'b0;
    c = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if (!(v && !m_pushed)) begin
        v = ($urandom_range(0, 99) < 45);
        case ($urandom_range(0, 3))
          0: c = 8'($urandom_range(8'h30, 8'h39));
          1: c = 8'($urandom_range(8'h41, 8'h5A));
          2: c = 8'($urandom_range(8'h61, 8'h7A));
          default: c = 8'($urandom);
        endcase
      end
      step(v, c, $urandom_range(0, 99) < 80);
    end
    idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
